// File: rtl/yaw_integ_pkg.sv
// Purpose : shared types and constants for the yaw integrator block.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package yaw_integ_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int CAL_SAMPLES_FAST = 16;
  localparam int CAL_SAMPLES_FULL = 2048;
  localparam int DEADBAND         = 8;
  localparam int HACC_W           = 24;
  localparam int CAL_SUM_W        = 27;
  localparam int CAL_CNT_W        = 11;

  // Clamp a 17-bit signed difference into the 16-bit signed range.
  // Overflow shows up as the two top bits disagreeing.
  function automatic logic [15:0] sat16(input logic [16:0] v);
    logic [15:0] r;
    if (v[16] != v[15]) begin
      r = v[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/yaw_offset_cal.sv
// Purpose : zero-rate offset calibration; averages N yaw samples (N = 16 or 2048).
// Latency : offset and done strobe register one cycle after the Nth sample;
//           last is combinational on the Nth sample.
// Backpr. : none; every smp_vld is consumed.
// Ports   : clk, rst (sync, active-high), clr (restart calibration),
//           smp_vld / yaw_rt (calibration sample), offset (16-bit signed),
//           last (Nth sample this cycle), done (1-cycle pulse after last).
module yaw_offset_cal
  import yaw_integ_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        smp_vld,
  input  logic [15:0] yaw_rt,
  output logic [15:0] offset,
  output logic        last,
  output logic        done
);

  localparam int N     = (FAST_SIM != 0) ? CAL_SAMPLES_FAST : CAL_SAMPLES_FULL;
  localparam int SHIFT = $clog2(N);

  logic signed [CAL_SUM_W-1:0] r_sum;
  logic [CAL_CNT_W-1:0]        r_cnt;
  logic [15:0]                 r_offset;
  logic                        r_done;

  logic signed [CAL_SUM_W-1:0] w_sum_nxt;
  logic signed [CAL_SUM_W-1:0] w_quot;
  logic                        w_last;

  assign w_sum_nxt = r_sum + $signed({{(CAL_SUM_W-16){yaw_rt[15]}}, yaw_rt});
  // Arithmetic shift gives floor division, so negative offsets round toward -inf.
  assign w_quot    = w_sum_nxt >>> SHIFT;
  assign w_last    = smp_vld && (r_cnt == CAL_CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum    <= '0;
      r_cnt    <= '0;
      r_offset <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clr) begin
        r_sum <= '0;
        r_cnt <= '0;
      end else if (smp_vld) begin
        if (w_last) begin
          r_offset <= w_quot[15:0];
          r_done   <= 1'b1;
          r_sum    <= '0;
          r_cnt    <= '0;
        end else begin
          r_sum <= w_sum_nxt;
          r_cnt <= r_cnt + CAL_CNT_W'(1);
        end
      end
    end
  end

  assign offset = r_offset;
  assign last   = w_last;
  assign done   = r_done;

endmodule

// File: rtl/yaw_integrator.sv
// Purpose : calibrates gyro zero-rate offset, integrates corrected yaw rate into a
//           12-bit heading, and nudges heading on guardrail (lftIR/rghtIR) hits.
// Latency : rdy and heading update one cycle after each RUN vld; cal_done one cycle
//           after the Nth calibration vld.
// Backpr. : none; every vld is consumed (back-to-back vld supported).
// Ports   : clk, rst (sync, active-high), strt_cal, vld, yaw_rt[15:0], moving,
//           lftIR, rghtIR -> cal_done, rdy, heading[11:0].
// Config  : define YAW_DEADBAND_EN to zero |comp| <= DEADBAND before integrating.
module yaw_integrator
  import yaw_integ_pkg::*;
#(
  parameter int FAST_SIM    = 1,
  parameter int FUSION_GAIN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cal,
  input  logic        vld,
  input  logic [15:0] yaw_rt,
  input  logic        moving,
  input  logic        lftIR,
  input  logic        rghtIR,
  output logic        cal_done,
  output logic        rdy,
  output logic [11:0] heading
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [HACC_W-1:0]   r_hacc;
  logic                r_rdy;

  logic                w_cal_smp;
  logic                w_run_smp;
  logic                w_cal_last;
  logic                w_cal_done;
  logic [15:0]         w_offset;
  logic [16:0]         w_diff;
  logic [15:0]         w_comp_sat;
  logic [15:0]         w_comp;
  logic [HACC_W-1:0]   w_fuse;
  logic [HACC_W-1:0]   w_hacc_nxt;

  // strt_cal takes priority: a vld in the same cycle is dropped.
  assign w_cal_smp = vld && !strt_cal && (r_state == CAL);
  assign w_run_smp = vld && !strt_cal && (r_state == RUN);

  yaw_offset_cal #(
    .FAST_SIM (FAST_SIM)
  ) u_cal (
    .clk     (clk),
    .rst     (rst),
    .clr     (strt_cal),
    .smp_vld (w_cal_smp),
    .yaw_rt  (yaw_rt),
    .offset  (w_offset),
    .last    (w_cal_last),
    .done    (w_cal_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (strt_cal) begin
      w_state_nxt = CAL;
    end else begin
      case (r_state)
        CAL:     if (w_cal_last) w_state_nxt = RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign w_diff     = {yaw_rt[15], yaw_rt} - {w_offset[15], w_offset};
  assign w_comp_sat = sat16(w_diff);

`ifdef YAW_DEADBAND_EN
  localparam logic signed [15:0] DB_POS = 16'(DEADBAND);
  localparam logic signed [15:0] DB_NEG = -16'(DEADBAND);
  assign w_comp = (($signed(w_comp_sat) <= DB_POS) && ($signed(w_comp_sat) >= DB_NEG))
                  ? 16'h0000 : w_comp_sat;
`else
  assign w_comp = w_comp_sat;
`endif

  // Exactly one guardrail active pulls the heading away from that side;
  // both or neither is treated as no information.
  always_comb begin
    w_fuse = '0;
    case ({lftIR, rghtIR})
      2'b10:   w_fuse = -HACC_W'(FUSION_GAIN);
      2'b01:   w_fuse =  HACC_W'(FUSION_GAIN);
      default: w_fuse = '0;
    endcase
  end

  // Modulo-2^24 wrap is intentional: heading rolls +180 -> -180.
  assign w_hacc_nxt = r_hacc + {{(HACC_W-16){w_comp[15]}}, w_comp} + w_fuse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hacc <= '0;
      r_rdy  <= 1'b0;
    end else begin
      r_rdy <= w_run_smp;
      if (w_cal_last) begin
        r_hacc <= '0;
      end else if (w_run_smp && moving) begin
        r_hacc <= w_hacc_nxt;
      end
    end
  end

  assign rdy      = r_rdy;
  assign cal_done = w_cal_done;
  assign heading  = r_hacc[HACC_W-1 -: 12];

endmodule

// File: tb/tb_yaw_integrator.sv
module tb_yaw_integrator;

  logic        clk = 1'b0;
  logic        rst, strt_cal, vld, moving, lftIR, rghtIR;
  logic [15:0] yaw_rt;
  logic        cal_done, rdy;
  logic [11:0] heading;

  always #5 clk = ~clk;

  yaw_integrator #(
    .FAST_SIM    (1),
    .FUSION_GAIN (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .strt_cal (strt_cal),
    .vld      (vld),
    .yaw_rt   (yaw_rt),
    .moving   (moving),
    .lftIR    (lftIR),
    .rghtIR   (rghtIR),
    .cal_done (cal_done),
    .rdy      (rdy),
    .heading  (heading)
  );

  int n_chk = 0;
  int n_bad = 0;

  // reference model: mode 0 idle, 1 calibrating, 2 running
  int m_mode, m_sum, m_cnt, m_off, m_hacc;
  int rdy_cnt, cd_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int exp_heading();
    return (m_hacc >> 12) & 32'hFFF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; strt_cal = 1'b0; vld = 1'b0; yaw_rt = '0;
    moving = 1'b0; lftIR = 1'b0; rghtIR = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_mode = 0; m_sum = 0; m_cnt = 0; m_off = 0; m_hacc = 0;
    rdy_cnt = 0; cd_cnt = 0;
    chk("rst_heading", {20'b0, heading}, 32'h0);
    chk("rst_rdy", {31'b0, rdy}, 32'h0);
    chk("rst_cal_done", {31'b0, cal_done}, 32'h0);
  endtask

  // One clock: apply inputs, advance the model, compare all outputs.
  task automatic step(input logic s, input logic v, input logic [15:0] y,
                      input logic mv, input logic l, input logic r);
    int ys, c, f;
    logic e_rdy, e_cd;
    @(negedge clk);
    strt_cal = s; vld = v; yaw_rt = y; moving = mv; lftIR = l; rghtIR = r;
    @(posedge clk);
    e_rdy = 1'b0;
    e_cd  = 1'b0;
    ys = int'($signed(y));
    if (s) begin
      m_mode = 1; m_sum = 0; m_cnt = 0;
    end else if (v && m_mode == 1) begin
      m_cnt++;
      if (m_cnt == 16) begin
        m_off  = (m_sum + ys) >>> 4;
        m_hacc = 0;
        m_mode = 2;
        m_sum  = 0;
        m_cnt  = 0;
        e_cd   = 1'b1;
      end else begin
        m_sum += ys;
      end
    end else if (v && m_mode == 2) begin
      e_rdy = 1'b1;
      c = ys - m_off;
      if (c > 32767)  c = 32767;
      if (c < -32768) c = -32768;
`ifdef YAW_DEADBAND_EN
      if (c >= -8 && c <= 8) c = 0;
`endif
      f = 0;
      if (l && !r) f = -256;
      if (r && !l) f = 256;
      if (mv) m_hacc = (m_hacc + c + f) & 32'hFFFFFF;
    end
    #1;
    chk("rdy", {31'b0, rdy}, {31'b0, e_rdy});
    chk("cal_done", {31'b0, cal_done}, {31'b0, e_cd});
    chk("heading", {20'b0, heading}, exp_heading());
    if (rdy) rdy_cnt++;
    if (cal_done) cd_cnt++;
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic calibrate(input logic [15:0] y);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, y, 1'b0, 1'b0, 1'b0);
    idle_cycle();
  endtask

  initial begin
    int base, prev;
    int wrap_seen;

    do_reset();

    // vld in IDLE is ignored
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    chk("idle_rdy_cnt", rdy_cnt, 0);
    chk("idle_heading", {20'b0, heading}, 32'h0);
    chk("idle_cal_done_cnt", cd_cnt, 0);

    // calibration to offset 0x20, then rate == offset gives no motion
    calibrate(16'h0020);
    chk("cal1_done_cnt", cd_cnt, 1);
    chk("cal1_rdy_cnt", rdy_cnt, 0);
    base = rdy_cnt;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    chk("zero_rate_heading", {20'b0, heading}, 32'h0);
    chk("zero_rate_rdy_cnt", rdy_cnt - base, 10);

    // 0x1000 net rate per vld advances heading one LSB per sample
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 16'h1020, 1'b1, 1'b0, 1'b0);
      chk("ramp_heading", {20'b0, heading}, i);
    end
    base = rdy_cnt;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h1020, 1'b0, 1'b0, 1'b0);
    chk("hold_heading", {20'b0, heading}, 32'h5);
    chk("hold_rdy_cnt", rdy_cnt - base, 5);

    // negative saturation: -32768 per vld, heading 5 -> 5-24
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
    chk("sat_neg_heading", {20'b0, heading}, 32'hFED);

    // positive run past +180 must wrap to -180
    wrap_seen = 0;
    prev = heading;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
      if (prev >= 12'h780 && prev <= 12'h7FF && heading >= 12'h800 && heading <= 12'h87F)
        wrap_seen = 1;
      prev = heading;
    end
    chk("wrap_seen", wrap_seen, 1);

    // guardrail fusion with zero offset and zero rate
    calibrate(16'h0000);
    chk("cal2_done_cnt", cd_cnt, 2);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("lft_heading", {20'b0, heading}, 32'hFFF);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0, 1'b1, 1'b1, 1'b1);
    chk("both_heading", {20'b0, heading}, 32'hFFF);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0, 1'b1, 1'b0, 1'b1);
    chk("rght_heading", {20'b0, heading}, 32'h0);

    // restart mid-calibration; the strt_cal cycle's sample is dropped
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    base = cd_cnt;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    chk("restart_no_done", cd_cnt - base, 0);
    step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    chk("restart_done", cd_cnt - base, 1);

    // small net rate (5) for 100 samples stays within heading LSB 0
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 16'h0015, 1'b1, 1'b0, 1'b0);
    chk("small_rate_heading", {20'b0, heading}, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] y;
      case ($urandom_range(0, 3))
        0:       y = $urandom();
        1:       y = 16'($signed($urandom_range(0, 40)) - 20);
        2:       y = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        default: y = 16'($signed($urandom_range(0, 8192)) - 4096);
      endcase
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 1) == 1), y,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
